// File: rtl/cpu_pkg.sv
// Shared opcode and ALU source-select encodings for the parametrised TD4 core.
package cpu_pkg;

  localparam logic [3:0] OP_ADD_A  = 4'b0000;
  localparam logic [3:0] OP_MOV_AB = 4'b0001;
  localparam logic [3:0] OP_IN_A   = 4'b0010;
  localparam logic [3:0] OP_MOV_AI = 4'b0011;
  localparam logic [3:0] OP_MOV_BA = 4'b0100;
  localparam logic [3:0] OP_ADD_B  = 4'b0101;
  localparam logic [3:0] OP_IN_B   = 4'b0110;
  localparam logic [3:0] OP_MOV_BI = 4'b0111;
  localparam logic [3:0] OP_HALT   = 4'b1000;
  localparam logic [3:0] OP_OUT_B  = 4'b1001;
  localparam logic [3:0] OP_OUT_I  = 4'b1011;
  localparam logic [3:0] OP_JNC    = 4'b1110;
  localparam logic [3:0] OP_JMP    = 4'b1111;

  localparam logic [1:0] SEL_A    = 2'b00;
  localparam logic [1:0] SEL_B    = 2'b01;
  localparam logic [1:0] SEL_IN   = 2'b10;
  localparam logic [1:0] SEL_ZERO = 2'b11;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational opcode decoder for param_td4_cpu.
// Optional HALT opcode enabled by defining CPU_HALT_EN.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic       carry,
  output logic [1:0] src_sel,
  output logic       load_a,
  output logic       load_b,
  output logic       load_out,
  output logic       jump,
  output logic       halt
);

  // Opcode to control-signal decode; non-writing opcodes add imm to zero
  always_comb begin
    src_sel  = SEL_ZERO;
    load_a   = 1'b0;
    load_b   = 1'b0;
    load_out = 1'b0;
    jump     = 1'b0;
    halt     = 1'b0;
    case (opcode)
      OP_ADD_A:  begin src_sel = SEL_A;    load_a = 1'b1; end
      OP_MOV_AB: begin src_sel = SEL_B;    load_a = 1'b1; end
      OP_IN_A:   begin src_sel = SEL_IN;   load_a = 1'b1; end
      OP_MOV_AI: begin src_sel = SEL_ZERO; load_a = 1'b1; end
      OP_MOV_BA: begin src_sel = SEL_A;    load_b = 1'b1; end
      OP_ADD_B:  begin src_sel = SEL_B;    load_b = 1'b1; end
      OP_IN_B:   begin src_sel = SEL_IN;   load_b = 1'b1; end
      OP_MOV_BI: begin src_sel = SEL_ZERO; load_b = 1'b1; end
      OP_OUT_B:  begin src_sel = SEL_B;    load_out = 1'b1; end
      OP_OUT_I:  begin src_sel = SEL_ZERO; load_out = 1'b1; end
      OP_JNC:    begin src_sel = SEL_ZERO; jump = ~carry; end
      OP_JMP:    begin src_sel = SEL_ZERO; jump = 1'b1; end
`ifdef CPU_HALT_EN
      OP_HALT:   begin src_sel = SEL_ZERO; halt = 1'b1; end
`endif
      default:   begin src_sel = SEL_ZERO; end
    endcase
  end

endmodule

// File: rtl/param_td4_cpu.sv
// W-bit TD4-style accumulator CPU executing one instruction per cpu_en strobe.
// Define CPU_HALT_EN to make opcode 1000 a sticky HALT.
module param_td4_cpu
  import cpu_pkg::*;
#(
  parameter int          W        = 4,
  parameter int          PC_W     = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cpu_en,
  output logic [PC_W-1:0] inst_adrs,
  input  logic [W+3:0]    inst,
  input  logic [W-1:0]    in_port,
  output logic [W-1:0]    out_port,
  output logic [W-1:0]    d_reg_a,
  output logic [W-1:0]    d_reg_b,
  output logic            d_carry,
  output logic            halted
);

  logic [PC_W-1:0] pc;
  logic [W-1:0]    reg_a;
  logic [W-1:0]    reg_b;
  logic [W-1:0]    out_reg;
  logic            carry;
  logic            halted_q;

  logic [3:0]      opcode;
  logic [W-1:0]    imm;
  logic [W-1:0]    src;
  logic [W:0]      sum;
  logic [1:0]      src_sel;
  logic            load_a;
  logic            load_b;
  logic            load_out;
  logic            jump;
  logic            halt;
  logic            exec;

  assign opcode = inst[W+3:W];
  assign imm    = inst[W-1:0];
  assign exec   = cpu_en & ~halted_q;

  cpu_decoder u_decoder (
    .opcode   (opcode),
    .carry    (carry),
    .src_sel  (src_sel),
    .load_a   (load_a),
    .load_b   (load_b),
    .load_out (load_out),
    .jump     (jump),
    .halt     (halt)
  );

  // ALU source mux
  always_comb begin
    src = '0;
    case (src_sel)
      SEL_A:   src = reg_a;
      SEL_B:   src = reg_b;
      SEL_IN:  src = in_port;
      default: src = '0;
    endcase
  end

  assign sum = {1'b0, src} + {1'b0, imm};

  // Architectural state update on executing edges only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc      <= PC_W'(RESET_PC);
      reg_a   <= '0;
      reg_b   <= '0;
      out_reg <= '0;
      carry   <= 1'b0;
    end else if (exec) begin
      carry <= sum[W];
      if (load_a) reg_a <= sum[W-1:0];
      else        reg_a <= reg_a;
      if (load_b) reg_b <= sum[W-1:0];
      else        reg_b <= reg_b;
      if (load_out) out_reg <= sum[W-1:0];
      else          out_reg <= out_reg;
      if (halt)      pc <= pc;
      else if (jump) pc <= imm[PC_W-1:0];
      else           pc <= pc + PC_W'(1);
    end else begin
      pc      <= pc;
      reg_a   <= reg_a;
      reg_b   <= reg_b;
      out_reg <= out_reg;
      carry   <= carry;
    end
  end

`ifdef CPU_HALT_EN
  // Sticky halt flag; only reset clears it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          halted_q <= 1'b0;
    else if (exec && halt) halted_q <= 1'b1;
    else                   halted_q <= halted_q;
  end
`else
  assign halted_q = 1'b0;
`endif

  assign inst_adrs = pc;
  assign out_port  = out_reg;
  assign d_reg_a   = reg_a;
  assign d_reg_b   = reg_b;
  assign d_carry   = carry;
  assign halted    = halted_q;

endmodule

// File: tb/tb_param_td4_cpu.sv
// Table-driven bench for param_td4_cpu (W=4 instance plus a W=8/PC_W=6 instance).
module tb_param_td4_cpu;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cpu_en;
  logic [7:0] inst;
  logic [3:0] in_port;
  logic [3:0] inst_adrs, out_port, d_reg_a, d_reg_b;
  logic       d_carry, halted;

  logic        cpu_en2;
  logic [11:0] inst2;
  logic [7:0]  in_port2;
  logic [5:0]  inst_adrs2;
  logic [7:0]  out_port2, d_reg_a2, d_reg_b2;
  logic        d_carry2, halted2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  param_td4_cpu #(.W(4), .PC_W(4), .RESET_PC(0)) dut (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en), .inst_adrs(inst_adrs),
    .inst(inst), .in_port(in_port), .out_port(out_port), .d_reg_a(d_reg_a),
    .d_reg_b(d_reg_b), .d_carry(d_carry), .halted(halted)
  );

  param_td4_cpu #(.W(8), .PC_W(6), .RESET_PC(0)) dut8 (
    .clk(clk), .reset_n(reset_n), .cpu_en(cpu_en2), .inst_adrs(inst_adrs2),
    .inst(inst2), .in_port(in_port2), .out_port(out_port2), .d_reg_a(d_reg_a2),
    .d_reg_b(d_reg_b2), .d_carry(d_carry2), .halted(halted2)
  );

  typedef struct {
    logic [7:0] inst;
    logic [3:0] in_port;
    logic [3:0] pc;
    logic [3:0] a;
    logic [3:0] b;
    logic       c;
    logic [3:0] out;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int pc, input int a, input int b,
                             input int c, input int o);
    check({tag, ".pc"},  int'(inst_adrs), pc);
    check({tag, ".a"},   int'(d_reg_a), a);
    check({tag, ".b"},   int'(d_reg_b), b);
    check({tag, ".c"},   int'(d_carry), c);
    check({tag, ".out"}, int'(out_port), o);
  endtask

  task automatic exec(input logic [7:0] i, input logic [3:0] p);
    @(negedge clk);
    inst = i; in_port = p; cpu_en = 1'b1;
    @(posedge clk);
    #1;
    cpu_en = 1'b0;
  endtask

  task automatic exec8(input logic [11:0] i);
    @(negedge clk);
    inst2 = i; cpu_en2 = 1'b1;
    @(posedge clk);
    #1;
    cpu_en2 = 1'b0;
  endtask

  initial begin
    //            inst   in    pc     a      b      c     out
    vecs[0]  = '{8'h33, 4'h0, 4'd1,  4'd3,  4'd0,  1'b0, 4'd0};
    vecs[1]  = '{8'h0E, 4'h0, 4'd2,  4'd1,  4'd0,  1'b1, 4'd0};
    vecs[2]  = '{8'hE0, 4'h0, 4'd3,  4'd1,  4'd0,  1'b0, 4'd0};
    vecs[3]  = '{8'hE0, 4'h0, 4'd0,  4'd1,  4'd0,  1'b0, 4'd0};
    vecs[4]  = '{8'h60, 4'h9, 4'd1,  4'd1,  4'd9,  1'b0, 4'd0};
    vecs[5]  = '{8'h91, 4'h0, 4'd2,  4'd1,  4'd9,  1'b0, 4'd10};
    vecs[6]  = '{8'hB5, 4'h0, 4'd3,  4'd1,  4'd9,  1'b0, 4'd5};
    vecs[7]  = '{8'h33, 4'h0, 4'd4,  4'd3,  4'd9,  1'b0, 4'd5};
    vecs[8]  = '{8'hFF, 4'h0, 4'd15, 4'd3,  4'd9,  1'b0, 4'd5};
    vecs[9]  = '{8'hA0, 4'h0, 4'd0,  4'd3,  4'd9,  1'b0, 4'd5};
    vecs[10] = '{8'h5F, 4'h0, 4'd1,  4'd3,  4'd8,  1'b1, 4'd5};
    vecs[11] = '{8'h40, 4'h0, 4'd2,  4'd3,  4'd3,  1'b0, 4'd5};
    vecs[12] = '{8'h10, 4'h0, 4'd3,  4'd3,  4'd3,  1'b0, 4'd5};
    vecs[13] = '{8'h20, 4'hF, 4'd4,  4'd15, 4'd3,  1'b0, 4'd5};
    vecs[14] = '{8'h01, 4'h0, 4'd5,  4'd0,  4'd3,  1'b1, 4'd5};
    vecs[15] = '{8'hE7, 4'h0, 4'd6,  4'd0,  4'd3,  1'b0, 4'd5};
    vecs[16] = '{8'h70, 4'h0, 4'd7,  4'd0,  4'd0,  1'b0, 4'd5};
    vecs[17] = '{8'hE9, 4'h0, 4'd9,  4'd0,  4'd0,  1'b0, 4'd5};

    reset_n = 1'b0; cpu_en = 1'b0; inst = 8'h00; in_port = 4'h0;
    cpu_en2 = 1'b0; inst2 = 12'h000; in_port2 = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_state("reset", 0, 0, 0, 0, 0);
    check("reset.halted", int'(halted), 0);
    @(negedge clk);
    reset_n = 1'b1;
    inst = 8'h0F;
    repeat (5) @(posedge clk);
    #1;
    check_state("idle_after_reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < 18; i++) begin
      exec(vecs[i].inst, vecs[i].in_port);
      check_state($sformatf("vec%0d", i), int'(vecs[i].pc), int'(vecs[i].a),
                  int'(vecs[i].b), int'(vecs[i].c), int'(vecs[i].out));
    end

    // strobe low: toggling inst/in_port must not change anything
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      inst = 8'(i * 37 + 3); in_port = 4'(i + 5);
    end
    @(posedge clk);
    #1;
    check_state("no_strobe", 9, 0, 0, 0, 5);

    exec(8'h80, 4'h0);
`ifdef CPU_HALT_EN
    check_state("halt", 9, 0, 0, 0, 5);
    check("halt.halted", int'(halted), 1);
    for (int i = 0; i < 3; i++) exec(8'h0F, 4'h0);
    check_state("halt_frozen", 9, 0, 0, 0, 5);
    check("halt_frozen.halted", int'(halted), 1);
`else
    check_state("op80_nop", 10, 0, 0, 0, 5);
    check("op80_nop.halted", int'(halted), 0);
    for (int i = 0; i < 3; i++) exec(8'h0F, 4'h0);
    check_state("after_op80", 13, 13, 0, 1, 5);
`endif

    // asynchronous reset away from any clock edge
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check_state("async_reset", 0, 0, 0, 0, 0);
    check("async_reset.halted", int'(halted), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // wide instance: W=8, PC_W=6
    exec8(12'h301);
    check("w8.mov.a", int'(d_reg_a2), 1);
    exec8(12'h0FF);
    check("w8.add.a", int'(d_reg_a2), 0);
    check("w8.add.c", int'(d_carry2), 1);
    check("w8.add.pc", int'(inst_adrs2), 2);
    exec8(12'hFC5);
    check("w8.jmp.pc", int'(inst_adrs2), 5);
    check("w8.jmp.c", int'(d_carry2), 0);
    check("w8.out", int'(out_port2), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
